biu_arbiter: RTL and testbench



---
 rtl/biu_arbiter.sv | 176 +++++++++++++++++
 tb/tb_biu_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biu_arbiter.sv
// biu_arbiter: round-robin read arbiter sharing one memory port among three BIUs.
//   clk, rst_n                 : clock, synchronous active-low reset
//   cli_req_addr/vld/rdy       : per-client request channels (client i at [i*ADDR_W +: ADDR_W])
//   cli_rsp_addr/data/vld/rdy  : response channel, addr/data broadcast, valid steered by tag
//   mem_req_addr/vld/rdy       : registered memory request channel
//   mem_rsp_addr/data/vld/rdy  : memory response channel (in request order)
//   arb_busy                   : any request outstanding
//   arb_err, arb_err_clr       : sticky orphan-response flag and its clear
module biu_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned OST_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3*ADDR_W-1:0]   cli_req_addr,
    input  logic [2:0]            cli_req_vld,
    output logic [2:0]            cli_req_rdy,
    output logic [ADDR_W-1:0]     cli_rsp_addr,
    output logic [DATA_W-1:0]     cli_rsp_data,
    output logic [2:0]            cli_rsp_vld,
    input  logic [2:0]            cli_rsp_rdy,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_vld,
    input  logic                  mem_req_rdy,
    input  logic [ADDR_W-1:0]     mem_rsp_addr,
    input  logic [DATA_W-1:0]     mem_rsp_data,
    input  logic                  mem_rsp_vld,
    output logic                  mem_rsp_rdy,
    output logic                  arb_busy,
    output logic                  arb_err,
    input  logic                  arb_err_clr
);

    localparam int unsigned PTR_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic                mem_req_vld_q, mem_req_vld_d;
    logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    ost_cnt_q, ost_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [1:0]          tag_q [OST_DEPTH];
    logic                arb_err_q, arb_err_d;

    logic                gnt_vld;
    logic [1:0]          gnt_id;
    logic [2:0]          scan;
    logic [ADDR_W-1:0]   gnt_addr;
    logic                load;
    logic                fifo_empty;
    logic [1:0]          head;
    logic                rsp_hs;
    logic                err_set;

    // Round-robin scan: walk backwards so the client closest to rr_ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 2'd0;
        scan    = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            scan = {1'b0, rr_ptr_q} + 3'(k);
            if (scan >= 3'd3) begin
                scan = scan - 3'd3;
            end
            if (cli_req_vld[scan[1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = scan[1:0];
            end
        end
    end

    // Address of the granted client.
    always_comb begin
        case (gnt_id)
            2'd1:    gnt_addr = cli_req_addr[1*ADDR_W +: ADDR_W];
            2'd2:    gnt_addr = cli_req_addr[2*ADDR_W +: ADDR_W];
            default: gnt_addr = cli_req_addr[0 +: ADDR_W];
        endcase
    end

    // Credit check uses the registered count, so a same-cycle response cannot free a slot.
    assign load        = (!mem_req_vld_q || mem_req_rdy) && (ost_cnt_q < CNT_W'(OST_DEPTH)) && gnt_vld;
    assign cli_req_rdy = load ? (3'b001 << gnt_id) : 3'b000;

    // Response steering by the oldest outstanding tag; orphan responses are sunk.
    assign fifo_empty = (ost_cnt_q == '0);
    assign head       = tag_q[rd_ptr_q];

    always_comb begin
        cli_rsp_vld = 3'b000;
        mem_rsp_rdy = 1'b0;
        if (!fifo_empty) begin
            cli_rsp_vld[head] = mem_rsp_vld;
            mem_rsp_rdy       = cli_rsp_rdy[head];
        end else begin
            mem_rsp_rdy = mem_rsp_vld;
        end
    end

    assign rsp_hs  = !fifo_empty && mem_rsp_vld && cli_rsp_rdy[head];
    assign err_set = fifo_empty && mem_rsp_vld;

    // Next-state logic.
    always_comb begin
        mem_req_vld_d  = mem_req_vld_q;
        mem_req_addr_d = mem_req_addr_q;
        rr_ptr_d       = rr_ptr_q;
        ost_cnt_d      = ost_cnt_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        arb_err_d      = arb_err_q;

        if (load) begin
            mem_req_vld_d  = 1'b1;
            mem_req_addr_d = gnt_addr;
            rr_ptr_d       = (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
            wr_ptr_d       = wr_ptr_q + PTR_W'(1);
        end else if (mem_req_vld_q && mem_req_rdy) begin
            mem_req_vld_d = 1'b0;
        end

        if (rsp_hs) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({load, rsp_hs})
            2'b10:   ost_cnt_d = ost_cnt_q + CNT_W'(1);
            2'b01:   ost_cnt_d = ost_cnt_q - CNT_W'(1);
            default: ost_cnt_d = ost_cnt_q;
        endcase

        // Set has priority over clear.
        if (err_set) begin
            arb_err_d = 1'b1;
        end else if (arb_err_clr) begin
            arb_err_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req_vld_q  <= 1'b0;
            mem_req_addr_q <= '0;
            rr_ptr_q       <= 2'd0;
            ost_cnt_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            arb_err_q      <= 1'b0;
            for (int i = 0; i < int'(OST_DEPTH); i++) begin
                tag_q[i] <= 2'd0;
            end
        end else begin
            mem_req_vld_q  <= mem_req_vld_d;
            mem_req_addr_q <= mem_req_addr_d;
            rr_ptr_q       <= rr_ptr_d;
            ost_cnt_q      <= ost_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            arb_err_q      <= arb_err_d;
            if (load) begin
                tag_q[wr_ptr_q] <= gnt_id;
            end
        end
    end

    assign mem_req_vld  = mem_req_vld_q;
    assign mem_req_addr = mem_req_addr_q;
    assign cli_rsp_addr = mem_rsp_addr;
    assign cli_rsp_data = mem_rsp_data;
    assign arb_busy     = (ost_cnt_q != '0);
    assign arb_err      = arb_err_q;

endmodule

// File: tb/tb_biu_arbiter.sv
// tb_biu_arbiter: randomized scoreboard bench for biu_arbiter with a transaction-level
// reference model (arbitration rule, credit count, in-order ID queue, sticky error).
module tb_biu_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int          OST = 4;

    logic           clk;
    logic           rst_n;
    logic [3*AW-1:0] cli_req_addr;
    logic [2:0]     cli_req_vld;
    logic [2:0]     cli_req_rdy;
    logic [AW-1:0]  cli_rsp_addr;
    logic [DW-1:0]  cli_rsp_data;
    logic [2:0]     cli_rsp_vld;
    logic [2:0]     cli_rsp_rdy;
    logic [AW-1:0]  mem_req_addr;
    logic           mem_req_vld;
    logic           mem_req_rdy;
    logic [AW-1:0]  mem_rsp_addr;
    logic [DW-1:0]  mem_rsp_data;
    logic           mem_rsp_vld;
    logic           mem_rsp_rdy;
    logic           arb_busy;
    logic           arb_err;
    logic           arb_err_clr;

    biu_arbiter #(.ADDR_W(AW), .DATA_W(DW), .OST_DEPTH(OST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cli_req_addr (cli_req_addr),
        .cli_req_vld  (cli_req_vld),
        .cli_req_rdy  (cli_req_rdy),
        .cli_rsp_addr (cli_rsp_addr),
        .cli_rsp_data (cli_rsp_data),
        .cli_rsp_vld  (cli_rsp_vld),
        .cli_rsp_rdy  (cli_rsp_rdy),
        .mem_req_addr (mem_req_addr),
        .mem_req_vld  (mem_req_vld),
        .mem_req_rdy  (mem_req_rdy),
        .mem_rsp_addr (mem_rsp_addr),
        .mem_rsp_data (mem_rsp_data),
        .mem_rsp_vld  (mem_rsp_vld),
        .mem_rsp_rdy  (mem_rsp_rdy),
        .arb_busy     (arb_busy),
        .arb_err      (arb_err),
        .arb_err_clr  (arb_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] req_rdy;
        logic [2:0] rsp_vld;
        logic       mrsp_rdy;
        logic       busy;
        logic       err;
        logic       mvld;
    } cyc_t;

    typedef struct packed {
        logic [1:0]    id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rsp_t;

    cyc_t          exp_cyc_q [$];
    logic [AW-1:0] exp_req_q [$];
    rsp_t          exp_rsp_q [$];

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int            m_rr, m_ost, m_grant;
    bit            m_mvld, m_err, m_rsp_hs, m_drop;
    logic [AW-1:0] m_maddr;
    int            tagq [$];
    logic [AW-1:0] mem_pend [$];
    bit            rsp_active;

    // Stimulus knobs
    int p_vld, p_mrdy, p_rsp, p_crdy;
    bit k_rst, k_stray, k_clr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply the effects of the clock edge that just happened.
    task automatic model_update();
        if (!rst_n) begin
            m_rr = 0; m_ost = 0; m_mvld = 1'b0; m_err = 1'b0; m_maddr = '0;
            tagq.delete(); mem_pend.delete(); exp_req_q.delete(); exp_rsp_q.delete();
            rsp_active = 1'b0;
            return;
        end
        if (m_mvld && mem_req_rdy) mem_pend.push_back(m_maddr);
        if (m_rsp_hs) begin
            void'(tagq.pop_front());
            void'(mem_pend.pop_front());
            rsp_active = 1'b0;
        end
        if (m_grant >= 0) begin
            tagq.push_back(m_grant);
            m_mvld  = 1'b1;
            m_maddr = cli_req_addr[m_grant*AW +: AW];
            m_rr    = (m_grant + 1) % 3;
            cli_req_addr[m_grant*AW +: AW] = $urandom;
        end else if (m_mvld && mem_req_rdy) begin
            m_mvld = 1'b0;
        end
        m_ost = m_ost + ((m_grant >= 0) ? 1 : 0) - (m_rsp_hs ? 1 : 0);
        if (m_drop) m_err = 1'b1;
        else if (arb_err_clr) m_err = 1'b0;
    endtask

    task automatic drive();
        rst_n = k_rst;
        m_grant = -1; m_rsp_hs = 1'b0; m_drop = 1'b0;
        if (!k_rst) begin
            cli_req_vld = '0; cli_rsp_rdy = '0; mem_req_rdy = 1'b0;
            mem_rsp_vld = 1'b0; arb_err_clr = 1'b0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            cli_req_vld[i] = ($urandom_range(99) < p_vld);
            cli_rsp_rdy[i] = ($urandom_range(99) < p_crdy);
        end
        mem_req_rdy = ($urandom_range(99) < p_mrdy);
        arb_err_clr = k_clr;
        if (k_stray) begin
            mem_rsp_vld  = 1'b1;
            mem_rsp_addr = $urandom;
            mem_rsp_data = $urandom;
        end else if (rsp_active) begin
            mem_rsp_vld = 1'b1;
        end else if (mem_pend.size() > 0 && $urandom_range(99) < p_rsp) begin
            mem_rsp_vld  = 1'b1;
            mem_rsp_addr = mem_pend[0];
            mem_rsp_data = $urandom;
            rsp_active   = 1'b1;
        end else begin
            mem_rsp_vld = 1'b0;
        end
    endtask

    // Expected behaviour for the current cycle from model state and driven inputs.
    task automatic model_eval();
        cyc_t e;
        rsp_t r;
        int   h;
        e = '0;
        if ((!m_mvld || mem_req_rdy) && m_ost < OST) begin
            for (int k = 0; k < 3; k++) begin
                if (m_grant < 0 && cli_req_vld[(m_rr + k) % 3]) m_grant = (m_rr + k) % 3;
            end
        end
        if (m_grant >= 0) e.req_rdy[m_grant] = 1'b1;
        if (tagq.size() > 0) begin
            h = tagq[0];
            e.rsp_vld[h] = mem_rsp_vld;
            e.mrsp_rdy   = cli_rsp_rdy[h];
            if (mem_rsp_vld && cli_rsp_rdy[h]) begin
                m_rsp_hs = 1'b1;
                r.id = 2'(h); r.addr = mem_rsp_addr; r.data = mem_rsp_data;
                exp_rsp_q.push_back(r);
            end
        end else begin
            e.mrsp_rdy = mem_rsp_vld;
            m_drop     = mem_rsp_vld;
        end
        if (m_grant >= 0) exp_req_q.push_back(cli_req_addr[m_grant*AW +: AW]);
        e.busy = (m_ost != 0);
        e.err  = m_err;
        e.mvld = m_mvld;
        exp_cyc_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        drive();
        if (k_rst) model_eval();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic knobs(input int v, input int mr, input int rs, input int cr);
        p_vld = v; p_mrdy = mr; p_rsp = rs; p_crdy = cr;
    endtask

    // Monitor: per-cycle outputs plus scoreboarded request and response transfers.
    always @(negedge clk) begin
        cyc_t e;
        rsp_t r;
        if (exp_cyc_q.size() > 0) begin
            e = exp_cyc_q.pop_front();
            chk("cli_req_rdy", 64'(cli_req_rdy), 64'(e.req_rdy));
            chk("cli_rsp_vld", 64'(cli_rsp_vld), 64'(e.rsp_vld));
            chk("mem_rsp_rdy", 64'(mem_rsp_rdy), 64'(e.mrsp_rdy));
            chk("arb_busy",    64'(arb_busy),    64'(e.busy));
            chk("arb_err",     64'(arb_err),     64'(e.err));
            chk("mem_req_vld", 64'(mem_req_vld), 64'(e.mvld));
        end
        if (rst_n && mem_req_vld && mem_req_rdy) begin
            if (exp_req_q.size() == 0) begin
                chk("mem_req_unexpected", 64'(mem_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("mem_req_addr", 64'(mem_req_addr), 64'(exp_req_q.pop_front()));
            end
        end
        if (rst_n && |(cli_rsp_vld & cli_rsp_rdy)) begin
            if (exp_rsp_q.size() == 0) begin
                chk("cli_rsp_unexpected", 64'(cli_rsp_vld), 64'd0);
            end else begin
                r = exp_rsp_q.pop_front();
                chk("rsp_client", 64'(cli_rsp_vld & cli_rsp_rdy), 64'(3'b001 << r.id));
                chk("rsp_addr",   64'(cli_rsp_addr), 64'(r.addr));
                chk("rsp_data",   64'(cli_rsp_data), 64'(r.data));
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0; cli_req_vld = '0; cli_rsp_rdy = '0; mem_req_rdy = 1'b0;
        mem_rsp_vld = 1'b0; mem_rsp_addr = '0; mem_rsp_data = '0; arb_err_clr = 1'b0;
        cli_req_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        m_rr = 0; m_ost = 0; m_grant = -1; m_mvld = 1'b0; m_err = 1'b0;
        m_rsp_hs = 1'b0; m_drop = 1'b0; m_maddr = '0; rsp_active = 1'b0;
        k_rst = 1'b0; k_stray = 1'b0; k_clr = 1'b0;
        knobs(0, 0, 0, 0);
        run(3);
        k_rst = 1'b1;

        // Single client 0 request with everything ready
        knobs(0, 100, 0, 100);
        step();
        cli_req_vld = 3'b001;
        exp_cyc_q.delete(); exp_req_q.delete(); m_grant = -1;
        model_eval();
        knobs(0, 100, 100, 100);
        run(6);

        // Saturation: credit runs out, then responses free slots one at a time
        knobs(100, 100, 0, 100);
        run(10);
        knobs(100, 100, 100, 100);
        run(20);

        // Memory back-pressure
        knobs(100, 0, 50, 100);
        run(8);

        // Random traffic with response back-pressure
        knobs(70, 70, 60, 70);
        run(1500);
        knobs(60, 50, 50, 40);
        run(1500);

        // Drain to idle
        knobs(0, 100, 100, 100);
        guard = 0;
        while ((m_ost != 0 || m_mvld) && guard < 200) begin
            step();
            guard++;
        end
        if (m_ost != 0 || m_mvld) begin
            n_chk++; n_err++;
            $display("FAIL drain_timeout: outstanding %0d required 0", m_ost);
        end
        run(2);

        // Orphan response, then clear, then set-vs-clear collision
        k_stray = 1'b1; step(); k_stray = 1'b0;
        run(2);
        k_clr = 1'b1; step(); k_clr = 1'b0;
        run(1);
        k_stray = 1'b1; k_clr = 1'b1; step(); k_stray = 1'b0; k_clr = 1'b0;
        run(2);
        k_clr = 1'b1; step(); k_clr = 1'b0;
        run(1);

        // Reset with requests outstanding, then a stray response
        knobs(100, 100, 0, 100);
        run(3);
        k_rst = 1'b0; run(2); k_rst = 1'b1;
        knobs(0, 100, 0, 100);
        run(2);
        k_stray = 1'b1; step(); k_stray = 1'b0;
        run(2);
        k_clr = 1'b1; step(); k_clr = 1'b0;
        run(3);

        @(negedge clk);
        chk("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
        chk("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
